// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache state encoding and fetch-address field layout.
package cpu_types_pkg;

    localparam int ICACHE_SETS = 16;
    localparam int ICACHE_IDX  = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG  = 32 - ICACHE_IDX - 2;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic [ICACHE_TAG-1:0] tag;
        logic [ICACHE_IDX-1:0] idx;
        logic [1:0]            bytoff;
    } icachef_t;

endpackage

// File: rtl/icache_frames.sv
// Valid/tag/data storage for the direct-mapped icache: one combinational read
// port, one synchronous write port, whole-array invalidate.
module icache_frames #(
    parameter int SETS = 16,
    parameter int IDX  = $clog2(SETS),
    parameter int TAGW = 30 - IDX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [IDX-1:0]  rd_idx,
    output logic            rd_valid,
    output logic [TAGW-1:0] rd_tag,
    output logic [31:0]     rd_data,
    input  logic            wr_en,
    input  logic [IDX-1:0]  wr_idx,
    input  logic [TAGW-1:0] wr_tag,
    input  logic [31:0]     wr_data
);

    logic [SETS-1:0] valid;
    logic [TAGW-1:0] tags [SETS];
    logic [31:0]     data [SETS];

    // Flush beats a fill landing on the same edge: the frame stays invalid.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with zero-latency hits, one-word
// miss fills from the memory controller, and saturating hit/miss counters.
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int          SETS    = ICACHE_SETS,
    parameter logic [31:0] PC_INIT = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 30 - IDX;

    icache_state_t   state, next_state;
    logic [29:0]     miss_addr;
    logic            rd_valid;
    logic [TAGW-1:0] rd_tag;
    logic            lookup_hit;
    logic            miss_start;
    logic            fill_we;
    logic            unused_bits;

    assign unused_bits = ^{PC_INIT, imemaddr[1:0]};

    icache_frames #(
        .SETS (SETS),
        .IDX  (IDX),
        .TAGW (TAGW)
    ) u_frames (
        .clk      (CLK),
        .rst      (RST),
        .flush    (flush),
        .rd_idx   (imemaddr[IDX+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (imemload),
        .wr_en    (fill_we & ~RST),
        .wr_idx   (miss_addr[IDX-1:0]),
        .wr_tag   (miss_addr[29:IDX]),
        .wr_data  (iload)
    );

    assign lookup_hit = rd_valid && (rd_tag == imemaddr[31:IDX+2]);

    // A flush cycle in IDLE neither hits nor starts a miss; the fetch simply
    // retries against the cleared array on the following cycle.
    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        iREN       = 1'b0;
        iaddr      = '0;
        miss_start = 1'b0;
        fill_we    = 1'b0;
        case (state)
            IDLE: begin
                if (imemREN && !flush) begin
                    if (lookup_hit) begin
                        ihit = 1'b1;
                    end else begin
                        miss_start = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = {miss_addr, 2'b00};
                if (!iwait) begin
                    fill_we    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= next_state;
            if (ihit && hit_count != 32'hFFFF_FFFF) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_start && miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (miss_start) begin
            miss_addr <= imemaddr[31:2];
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: fetches push expected words, a negedge
// monitor pops and compares on every ihit; a simple memory model serves fills.
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int errors = 0;
    int checks = 0;
    int nhits  = 0;
    int wcnt   = 0;
    logic [31:0] exp_q [$];

    localparam int LAT = 2;

    icache_direct #(.SETS(16), .PC_INIT(32'h0)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .flush      (flush),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2001_0005;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: busy for LAT cycles of each request, then returns the word.
    always @(posedge CLK) begin
        #1;
        if (iREN === 1'b1) begin
            if (wcnt < LAT) begin
                iwait = 1'b1;
                wcnt++;
            end else begin
                iwait = 1'b0;
                iload = mem_word(iaddr);
            end
        end else begin
            wcnt  = 0;
            iwait = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (RST === 1'b0 && ihit === 1'b1) begin
            nhits++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hit: addr %h data %h, no hit expected", imemaddr, imemload);
            end else begin
                chk("hit_data", imemload, exp_q.pop_front());
            end
        end
    end

    // Holds a fetch until n hits are seen; counts cycles with iREN high.
    task automatic fetch(input logic [31:0] a, input int n, input bit chk_addr, output int iren_cyc);
        int start;
        int t;
        imemaddr = a;
        imemREN  = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(mem_word(a));
        start    = nhits;
        iren_cyc = 0;
        t        = 0;
        while ((nhits - start) < n && t < 40) begin
            @(negedge CLK);
            #1;
            if (iREN === 1'b1) begin
                iren_cyc++;
                if (chk_addr) chk("fill_iaddr", iaddr, {a[31:2], 2'b00});
            end
            t++;
        end
        if ((nhits - start) < n) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: addr %h got %0d hits expected %0d", a, nhits - start, n);
            exp_q.delete();
        end
        @(posedge CLK);
        #2;
        imemREN = 1'b0;
    endtask

    task automatic branch(input logic [31:0] a, input logic [31:0] b, output int cyc);
        imemaddr = a;
        imemREN  = 1'b1;
        @(posedge CLK);
        #2;
        chk("branch_iren", {31'b0, iREN}, 32'd1);
        chk("branch_iaddr", iaddr, a);
        fetch(b, 1, 1'b0, cyc);
    endtask

    task automatic counters(input string name, input logic [31:0] h, input logic [31:0] m);
        chk({name, "_hits"}, hit_count, h);
        chk({name, "_misses"}, miss_count, m);
    endtask

    initial begin
        int cyc;
        int t;
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = '0;
        flush    = 1'b0;
        iwait    = 1'b1;
        iload    = '0;
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b0;
        chk("rst_ihit", {31'b0, ihit}, 32'd0);
        chk("rst_iren", {31'b0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        counters("rst", 32'd0, 32'd0);

        fetch(32'h40, 1, 1'b1, cyc);
        chk("cold_iren_cycles", cyc, 3);
        counters("cold", 32'd1, 32'd1);

        fetch(32'h40, 5, 1'b0, cyc);
        chk("repeat_iren_cycles", cyc, 0);
        counters("repeat", 32'd6, 32'd1);

        fetch(32'h80, 1, 1'b1, cyc);
        chk("conflict_iren_cycles", cyc, 3);
        fetch(32'h40, 1, 1'b1, cyc);
        chk("evicted_iren_cycles", cyc, 3);
        counters("conflict", 32'd8, 32'd3);

        // 0x100 and 0x200 share index 0, so 0x200 evicts the fresh 0x100 frame.
        branch(32'h100, 32'h200, cyc);
        chk("branch_iren_cycles", cyc, 6);
        fetch(32'h100, 1, 1'b1, cyc);
        chk("branch_refetch_cycles", cyc, 3);
        counters("branch", 32'd10, 32'd6);

        branch(32'h104, 32'h208, cyc);
        chk("branch2_iren_cycles", cyc, 6);
        fetch(32'h104, 1, 1'b0, cyc);
        chk("branch2_old_hits", cyc, 0);
        counters("branch2", 32'd12, 32'd8);

        fetch(32'h40, 1, 1'b1, cyc);
        flush = 1'b1;
        @(posedge CLK);
        #2;
        flush = 1'b0;
        fetch(32'h40, 1, 1'b1, cyc);
        chk("flush_pulse_cycles", cyc, 3);
        counters("flush", 32'd14, 32'd10);

        imemaddr = 32'h80;
        imemREN  = 1'b1;
        t = 0;
        do begin
            @(posedge CLK);
            #2;
            t++;
        end while (!(iREN === 1'b1 && iwait === 1'b0) && t < 20);
        chk("flush_edge_reached", {31'b0, iREN & ~iwait}, 32'd1);
        flush = 1'b1;
        @(posedge CLK);
        #2;
        flush = 1'b0;
        chk("flush_edge_idle", {31'b0, iREN}, 32'd0);
        fetch(32'h80, 1, 1'b1, cyc);
        chk("flush_edge_cycles", cyc, 3);
        counters("flush_edge", 32'd15, 32'd12);

        imemaddr = 32'h14;
        imemREN  = 1'b1;
        @(posedge CLK);
        #2;
        chk("rstfill_in_fill", {31'b0, iREN}, 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        chk("rstfill_iren", {31'b0, iREN}, 32'd0);
        counters("rstfill", 32'd0, 32'd0);
        fetch(32'h14, 1, 1'b1, cyc);
        chk("rstfill_frame_invalid", cyc, 3);
        counters("rstfill_after", 32'd1, 32'd1);

        repeat (2) @(posedge CLK);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
